mux_scan: RTL and testbench

MUX_SCAN -- requirements
Module: mux_scan

---
 rtl/mux_pkg.sv | 9 +
 rtl/rr_pick.sv | 28 ++
 rtl/mux_scan.sv | 105 ++++++++++
 tb/tb_mux_scan.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types for the channel multiplexer: the arbitration mode selector.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: one-hot grant of the first requesting channel,
// searching upward from ptr and wrapping past N_CH-1 back to channel 0.
module rr_pick #(
  parameter int N_CH = 4,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] grant
);

  // Walk the channels in rotated order and keep only the first hit.
  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(ptr) + k) % N_CH;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan.sv
// Channel multiplexer with a single-entry registered output. Channels are
// picked either by an explicit select (fixed mode) or by a rotating-priority
// scan (round-robin mode); the output register accepts a new word whenever
// it is empty or being drained in the same cycle.
import mux_pkg::*;

module mux_scan #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH-1:0][WIDTH-1:0] d,
  input  logic [N_CH-1:0]            in_valid,
  output logic [N_CH-1:0]            in_ready,
  input  mode_t                      mode,
  input  logic [CH_W-1:0]            sel,
  output logic [WIDTH-1:0]           z,
  output logic [CH_W-1:0]            z_ch,
  output logic                       z_valid,
  input  logic                       out_ready
);

  localparam int PAD_N = 1 << CH_W;

  logic [WIDTH-1:0] r_z;
  logic [CH_W-1:0]  r_z_ch;
  logic             r_z_valid;
  logic [CH_W-1:0]  r_ptr;

  logic [N_CH-1:0]  w_rr_gnt;
  logic [CH_W-1:0]  w_rr_idx;
  logic [CH_W-1:0]  w_ptr_next;
  logic [PAD_N-1:0] w_valid_pad;
  logic             w_fixed_hit;
  logic [CH_W-1:0]  w_gnt_idx;
  logic             w_any;
  logic             w_load_en;
  logic             w_take;
  logic [WIDTH-1:0] w_word;

  rr_pick #(.N_CH(N_CH)) u_rr_pick (
    .req   (in_valid),
    .ptr   (r_ptr),
    .grant (w_rr_gnt)
  );

  // Encode the round-robin one-hot grant into a channel index.
  always_comb begin
    w_rr_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_rr_gnt[i]) w_rr_idx = CH_W'(i);
    end
  end

  // Zero-pad in_valid to the full select range so an out-of-range sel
  // (non-power-of-2 N_CH) reads a 0 and never grants.
  always_comb begin
    w_valid_pad           = '0;
    w_valid_pad[N_CH-1:0] = in_valid;
  end

  assign w_fixed_hit = w_valid_pad[sel];
  assign w_gnt_idx   = (mode == MODE_RR) ? w_rr_idx : sel;
  assign w_any       = (mode == MODE_RR) ? (|w_rr_gnt) : w_fixed_hit;
  assign w_load_en   = !r_z_valid || out_ready;
  assign w_take      = rst_n && w_load_en && w_any;
  assign w_ptr_next  = (w_rr_idx == CH_W'(N_CH - 1)) ? '0 : w_rr_idx + 1'b1;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
    assign in_ready[gi] = w_take && (w_gnt_idx == CH_W'(gi));
  end

  // Select the accepted channel's word for the output register.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (in_ready[i]) w_word = d[i];
    end
  end

  // Output register and round-robin pointer; a drain without a new grant
  // only drops valid so the last word stays visible for debug.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z       <= '0;
      r_z_ch    <= '0;
      r_z_valid <= 1'b0;
      r_ptr     <= '0;
    end else if (w_take) begin
      r_z       <= w_word;
      r_z_ch    <= w_gnt_idx;
      r_z_valid <= 1'b1;
      if (mode == MODE_RR) r_ptr <= w_ptr_next;
    end else if (out_ready) begin
      r_z_valid <= 1'b0;
    end
  end

  assign z       = r_z;
  assign z_ch    = r_z_ch;
  assign z_valid = r_z_valid;

endmodule

// File: tb/tb_mux_scan.sv
// Directed table plus reset/corner sequences for a 4x8 instance, and a
// reference-model comparison for a 3x16 instance.
module tb_mux_scan;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- 4 x 8 instance ----------------
  logic [3:0][7:0] d4;
  logic [3:0]      iv4;
  logic [3:0]      ir4;
  mode_t           mode4;
  logic [1:0]      sel4;
  logic [7:0]      z4;
  logic [1:0]      zch4;
  logic            zv4;
  logic            or4;

  mux_scan #(.N_CH(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .d(d4), .in_valid(iv4), .in_ready(ir4),
    .mode(mode4), .sel(sel4), .z(z4), .z_ch(zch4), .z_valid(zv4),
    .out_ready(or4)
  );

  // ---------------- 3 x 16 instance ----------------
  logic [2:0][15:0] d3;
  logic [2:0]       iv3;
  logic [2:0]       ir3;
  mode_t            mode3;
  logic [1:0]       sel3;
  logic [15:0]      z3;
  logic [1:0]       zch3;
  logic             zv3;
  logic             or3;

  mux_scan #(.N_CH(3), .WIDTH(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .d(d3), .in_valid(iv3), .in_ready(ir3),
    .mode(mode3), .sel(sel3), .z(z3), .z_ch(zch3), .z_valid(zv3),
    .out_ready(or3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    mode_t      mode;
    logic [1:0] sel;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] exp_ir;
    logic       exp_v;
    logic [1:0] exp_ch;
    logic [7:0] exp_z;
  } vec_t;

  vec_t tbl[20];

  initial begin
    // mode, sel, in_valid, out_ready, in_ready, z_valid, z_ch, z (after edge)
    tbl[0]  = '{MODE_FIXED, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC2};
    tbl[1]  = '{MODE_RR,    2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[2]  = '{MODE_RR,    2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1};
    tbl[3]  = '{MODE_RR,    2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC2};
    tbl[4]  = '{MODE_RR,    2'd0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3};
    tbl[5]  = '{MODE_RR,    2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[6]  = '{MODE_RR,    2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0};
    tbl[7]  = '{MODE_RR,    2'd0, 4'h0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'hA0};
    tbl[8]  = '{MODE_RR,    2'd0, 4'h4, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC2};
    tbl[9]  = '{MODE_RR,    2'd0, 4'h2, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1};
    tbl[10] = '{MODE_RR,    2'd0, 4'h8, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hD3};
    tbl[11] = '{MODE_RR,    2'd0, 4'h3, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[12] = '{MODE_RR,    2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0};
    tbl[13] = '{MODE_RR,    2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0};
    tbl[14] = '{MODE_RR,    2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0};
    tbl[15] = '{MODE_RR,    2'd0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1};
    tbl[16] = '{MODE_FIXED, 2'd3, 4'h7, 1'b1, 4'b0000, 1'b0, 2'd1, 8'hB1};
    tbl[17] = '{MODE_FIXED, 2'd0, 4'h7, 1'b0, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[18] = '{MODE_RR,    2'd0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0};
    tbl[19] = '{MODE_RR,    2'd0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC2};
  end

  // Reference model state for the 3-channel instance.
  logic [15:0] m_z;
  logic [1:0]  m_ch;
  logic        m_v;
  int          m_ptr;

  initial begin
    d4    = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    iv4   = '0;
    mode4 = MODE_FIXED;
    sel4  = '0;
    or4   = 1'b0;
    d3    = '0;
    iv3   = '0;
    mode3 = MODE_FIXED;
    sel3  = '0;
    or3   = 1'b0;

    // Reset state, held across a clock edge.
    #7;
    chk("rst_z", 32'(z4), 32'h0);
    chk("rst_zch", 32'(zch4), 32'h0);
    chk("rst_zv", 32'(zv4), 32'h0);
    chk("rst_ir", 32'(ir4), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table for the 4-channel instance.
    for (int r = 0; r < 20; r++) begin
      @(negedge clk);
      mode4 = tbl[r].mode;
      sel4  = tbl[r].sel;
      iv4   = tbl[r].iv;
      or4   = tbl[r].ordy;
      #1;
      chk($sformatf("row%0d_in_ready", r), 32'(ir4), 32'(tbl[r].exp_ir));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_z_valid", r), 32'(zv4), 32'(tbl[r].exp_v));
      chk($sformatf("row%0d_z_ch", r), 32'(zch4), 32'(tbl[r].exp_ch));
      chk($sformatf("row%0d_z", r), 32'(z4), 32'(tbl[r].exp_z));
      $display("row %0d: mode=%0d sel=%0d iv=%b ordy=%b -> ir=%b z=%h ch=%0d v=%b",
               r, mode4, sel4, iv4, or4, ir4, z4, zch4, zv4);
    end

    // Asynchronous reset mid-cycle while a word is held (ptr was 3).
    #2;
    mode4 = MODE_RR;
    iv4   = 4'hF;
    or4   = 1'b0;
    chk("pre_rst_zv", 32'(zv4), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_z", 32'(z4), 32'h0);
    chk("async_rst_zch", 32'(zch4), 32'h0);
    chk("async_rst_zv", 32'(zv4), 32'h0);
    chk("async_rst_ir", 32'(ir4), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    or4   = 1'b1;
    #1;
    chk("post_rst_ir", 32'(ir4), 32'b0001);
    @(posedge clk);
    #1;
    chk("post_rst_z", 32'(z4), 32'hA0);
    chk("post_rst_zch", 32'(zch4), 32'h0);
    chk("post_rst_zv", 32'(zv4), 32'h1);
    $display("async reset sequence: z=%h ch=%0d v=%b", z4, zch4, zv4);

    // 3-channel instance: out-of-range select must never grant.
    @(negedge clk);
    mode3 = MODE_FIXED;
    sel3  = 2'd3;
    iv3   = 3'b111;
    d3    = {16'h3333, 16'h2222, 16'h1111};
    or3   = 1'b1;
    #1;
    chk("n3_sel3_ir", 32'(ir3), 32'h0);
    @(posedge clk);
    #1;
    chk("n3_sel3_zv", 32'(zv3), 32'h0);
    $display("n3 sel=3: ir=%b v=%b", ir3, zv3);

    // 3-channel instance against a reference model, random traffic.
    m_z = '0; m_ch = '0; m_v = 1'b0; m_ptr = 0;
    for (int c = 0; c < 1000; c++) begin
      int         g;
      logic [2:0] exp_ir;
      @(negedge clk);
      mode3 = ($urandom_range(0, 1) == 1) ? MODE_RR : MODE_FIXED;
      sel3  = 2'($urandom_range(0, 3));
      iv3   = 3'($urandom_range(0, 7));
      or3   = 1'($urandom_range(0, 1));
      d3    = {16'($urandom), 16'($urandom), 16'($urandom)};
      g = -1;
      if (!m_v || or3) begin
        if (mode3 == MODE_FIXED) begin
          if (sel3 < 2'd3 && iv3[sel3]) g = int'(sel3);
        end else begin
          for (int k = 2; k >= 0; k--) begin
            if (iv3[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
          end
        end
      end
      exp_ir = (g >= 0) ? 3'(1 << g) : 3'b000;
      #1;
      chk($sformatf("n3_c%0d_ir", c), 32'(ir3), 32'(exp_ir));
      if (g >= 0) begin
        m_z  = d3[g];
        m_ch = 2'(g);
        m_v  = 1'b1;
        if (mode3 == MODE_RR) m_ptr = (g + 1) % 3;
      end else if (or3) begin
        m_v = 1'b0;
      end
      @(posedge clk);
      #1;
      chk($sformatf("n3_c%0d_out", c), {13'h0, zv3, zch3, z3}, {13'h0, m_v, m_ch, m_z});
    end
    $display("n3 random run: 1000 cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
